// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ
// requesters and parks each result in a per-requester response slot.

package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLTS = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11
  } alu_opcode_e;

  // Contents of one response slot
  typedef struct packed {
    logic              error;
    logic [DATA_W-1:0] result;
  } alu_rsp_t;

endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_ip,
  input  logic [NUM_REQ-1:0]             req_valid_ip,
  input  alu_opcode_e                    req_op_ip [NUM_REQ],
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a_ip,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b_ip,
  output logic [NUM_REQ-1:0]             req_ready_op,
  output logic                           alu_enable_op,
  output alu_opcode_e                    alu_operator_op,
  output logic [DATA_W-1:0]              alu_operand_a_op,
  output logic [DATA_W-1:0]              alu_operand_b_op,
  input  logic [DATA_W-1:0]              alu_result_ip,
  input  logic                           alu_valid_ip,
  output logic [NUM_REQ-1:0]             rsp_valid_op,
  output logic [NUM_REQ-1:0][DATA_W-1:0] rsp_result_op,
  output logic [NUM_REQ-1:0]             rsp_error_op,
  input  logic [NUM_REQ-1:0]             rsp_ready_ip
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] slot_full_q;
  alu_rsp_t           slot_q [NUM_REQ];

  logic [NUM_REQ-1:0] slot_free;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   cand_idx;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;

  // Eligibility: valid request whose slot is empty or draining this cycle;
  // nothing is eligible during flush or while reset is held.
  always_comb begin
    slot_free = ~slot_full_q | rsp_ready_ip;
    eligible  = req_valid_ip & slot_free & {NUM_REQ{reset & ~flush_ip}};
  end

  // Round-robin search starting at ptr_q; first eligible requester wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Pointer advances past the winner; holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Grant and ALU operand mux; idle drives ADD with zero operands
  always_comb begin
    req_ready_op     = '0;
    alu_enable_op    = 1'b0;
    alu_operator_op  = ALU_ADD;
    alu_operand_a_op = '0;
    alu_operand_b_op = '0;
    if (grant_vld) begin
      req_ready_op[grant_idx] = 1'b1;
      alu_enable_op           = 1'b1;
      alu_operator_op         = req_op_ip[grant_idx];
      alu_operand_a_op        = req_a_ip[grant_idx];
      alu_operand_b_op        = req_b_ip[grant_idx];
    end
  end

  // Pointer and response slots: capture on grant, clear on drain or flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      slot_full_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (flush_ip) begin
          slot_full_q[i] <= 1'b0;
        end else if (grant_vld && (grant_idx == IDX_W'(i))) begin
          slot_full_q[i]   <= 1'b1;
          slot_q[i].result <= alu_result_ip;
          slot_q[i].error  <= ~alu_valid_ip;
        end else if (rsp_ready_ip[i]) begin
          slot_full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Response outputs straight from slot state
  always_comb begin
    rsp_valid_op  = slot_full_q;
    rsp_result_op = '0;
    rsp_error_op  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_result_op[i] = slot_q[i].result;
      rsp_error_op[i]  = slot_q[i].error;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stand-in, behavioural arbiter model, scenario tasks.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush;
  logic [N-1:0]         req_valid;
  alu_opcode_e          req_op [N];
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic [N-1:0]         req_ready_op;
  logic                 alu_enable_op;
  alu_opcode_e          alu_operator_op;
  logic [31:0]          alu_operand_a_op;
  logic [31:0]          alu_operand_b_op;
  logic [31:0]          alu_result;
  logic                 alu_valid;
  logic [N-1:0]         rsp_valid_op;
  logic [N-1:0][31:0]   rsp_result_op;
  logic [N-1:0]         rsp_error_op;
  logic [N-1:0]         rsp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_ip         (flush),
    .req_valid_ip     (req_valid),
    .req_op_ip        (req_op),
    .req_a_ip         (req_a),
    .req_b_ip         (req_b),
    .req_ready_op     (req_ready_op),
    .alu_enable_op    (alu_enable_op),
    .alu_operator_op  (alu_operator_op),
    .alu_operand_a_op (alu_operand_a_op),
    .alu_operand_b_op (alu_operand_b_op),
    .alu_result_ip    (alu_result),
    .alu_valid_ip     (alu_valid),
    .rsp_valid_op     (rsp_valid_op),
    .rsp_result_op    (rsp_result_op),
    .rsp_error_op     (rsp_error_op),
    .rsp_ready_ip     (rsp_ready)
  );

  // ALU behaviour: {valid, result}; MUL/DIV are unsupported
  function automatic logic [32:0] alu_fn(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return {1'b1, a + b};
      ALU_SUB:  return {1'b1, a - b};
      ALU_AND:  return {1'b1, a & b};
      ALU_OR:   return {1'b1, a | b};
      ALU_XOR:  return {1'b1, a ^ b};
      ALU_SLTS: return {1'b1, 31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {1'b1, 31'd0, (a < b)};
      ALU_SLL:  return {1'b1, a << b[4:0]};
      ALU_SRL:  return {1'b1, a >> b[4:0]};
      ALU_SRA:  return {1'b1, 32'($signed(a) >>> b[4:0])};
      default:  return {1'b0, 32'd0};
    endcase
  endfunction

  always_comb {alu_valid, alu_result} = alu_fn(alu_operator_op, alu_operand_a_op, alu_operand_b_op);

  // Reference model state
  bit           m_full [N];
  logic [31:0]  m_res  [N];
  bit           m_err  [N];
  int           m_ptr;

  int                 exp_g;
  logic [N-1:0]       exp_ready;
  logic               exp_en;
  alu_opcode_e        exp_op;
  logic [31:0]        exp_a, exp_b;
  logic [N-1:0]       exp_rv;
  logic [N-1:0][31:0] exp_rr;
  logic [N-1:0]       exp_re;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_res[i] = '0; m_err[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_pack();
    for (int i = 0; i < N; i++) begin
      exp_rv[i] = m_full[i]; exp_rr[i] = m_res[i]; exp_re[i] = m_err[i];
    end
  endtask

  // Who should win this cycle, and what the ALU bus should carry
  task automatic model_eval();
    int i;
    exp_g = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (exp_g < 0 && reset && !flush && req_valid[i] && (!m_full[i] || rsp_ready[i]))
        exp_g = i;
    end
    exp_ready = '0; exp_en = 0; exp_op = ALU_ADD; exp_a = '0; exp_b = '0;
    if (exp_g >= 0) begin
      exp_ready[exp_g] = 1'b1; exp_en = 1;
      exp_op = req_op[exp_g]; exp_a = req_a[exp_g]; exp_b = req_b[exp_g];
    end
  endtask

  // Apply one clock edge to the model with the current inputs
  task automatic model_commit();
    logic [32:0] r;
    model_eval();
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flush) m_full[i] = 0;
        else if (exp_g == i) begin
          r = alu_fn(req_op[i], req_a[i], req_b[i]);
          m_full[i] = 1; m_res[i] = r[31:0]; m_err[i] = !r[32];
        end else if (rsp_ready[i]) m_full[i] = 0;
      end
      if (exp_g >= 0) m_ptr = (exp_g + 1) % N;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
    model_pack();
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_inputs(int flush_pct);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = ($urandom_range(0, 3) != 0);
      req_op[i]    = alu_opcode_e'(4'($urandom_range(0, 11)));
      req_a[i]     = rand_data();
      req_b[i]     = rand_data();
      rsp_ready[i] = 1'($urandom_range(0, 1));
    end
    flush = ($urandom_range(0, 99) < flush_pct);
  endtask

  task automatic test_reset();
    reset = 0; flush = 0; req_valid = '1; rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_op[i] = ALU_SUB; req_a[i] = 32'd9 + 32'(i); req_b[i] = 32'd1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready_op !== '0 || alu_enable_op !== 1'b0 || alu_operator_op !== ALU_ADD ||
        alu_operand_a_op !== '0 || alu_operand_b_op !== '0) begin
      errors++;
      $display("FAIL reset_alu: ready=%b en=%b op=%0d a=%h b=%h required all idle", req_ready_op,
               alu_enable_op, alu_operator_op, alu_operand_a_op, alu_operand_b_op);
    end
    checks++;
    if (rsp_valid_op !== '0 || rsp_result_op !== '0 || rsp_error_op !== '0) begin
      errors++;
      $display("FAIL reset_rsp: v=%b r=%h e=%b required zero", rsp_valid_op, rsp_result_op, rsp_error_op);
    end
    model_reset();
    model_pack();
    reset = 1;
    #1;
    checks++;
    if (req_ready_op !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b required 01", req_ready_op);
    end
    tick();
    checks++;
    if (rsp_valid_op !== exp_rv || rsp_result_op !== exp_rr || rsp_error_op !== exp_re) begin
      errors++;
      $display("FAIL reset_rsp_after: v=%b r=%h e=%b required v=%b r=%h e=%b",
               rsp_valid_op, rsp_result_op, rsp_error_op, exp_rv, exp_rr, exp_re);
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0) ? 2'b01 : 2'b00;
      req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
      rsp_ready = (c == 0 || c == 4) ? 2'b01 : 2'b00;
      @(negedge clk); model_eval();
      checks++;
      if (req_ready_op !== exp_ready || alu_enable_op !== exp_en || alu_operator_op !== exp_op ||
          alu_operand_a_op !== exp_a || alu_operand_b_op !== exp_b) begin
        errors++;
        $display("FAIL single_grant c=%0d: ready=%b en=%b a=%h required ready=%b en=%b a=%h",
                 c, req_ready_op, alu_enable_op, alu_operand_a_op, exp_ready, exp_en, exp_a);
      end
      tick();
      checks++;
      if (rsp_valid_op[0] !== (c < 4) || rsp_result_op[0] !== 32'd12 || rsp_error_op[0] !== 1'b0 ||
          rsp_valid_op !== exp_rv) begin
        errors++;
        $display("FAIL single_slot c=%0d: v=%b r=%0d e=%b required v0=%b r=12 e=0",
                 c, rsp_valid_op, rsp_result_op[0], rsp_error_op[0], (c < 4));
      end
    end
  endtask

  task automatic test_round_robin();
    req_valid = 2'b11; rsp_ready = 2'b11; flush = 0;
    req_op[0] = ALU_SUB;  req_a[0] = 32'd3;          req_b[0] = 32'd5;
    req_op[1] = ALU_SLTS; req_a[1] = 32'hFFFF_FFFF;  req_b[1] = 32'd1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        for (int i = 0; i < N; i++) begin
          req_op[i] = alu_opcode_e'(4'($urandom_range(0, 9)));
          req_a[i] = rand_data(); req_b[i] = rand_data();
        end
      end
      @(negedge clk); model_eval();
      checks++;
      if (req_ready_op !== exp_ready || alu_operator_op !== exp_op ||
          alu_operand_a_op !== exp_a || alu_operand_b_op !== exp_b) begin
        errors++;
        $display("FAIL rr_grant c=%0d: ready=%b op=%0d required ready=%b op=%0d",
                 c, req_ready_op, alu_operator_op, exp_ready, exp_op);
      end
      tick();
      checks++;
      if (rsp_valid_op !== exp_rv || rsp_result_op !== exp_rr || rsp_error_op !== exp_re) begin
        errors++;
        $display("FAIL rr_rsp c=%0d: v=%b r=%h e=%b required v=%b r=%h e=%b",
                 c, rsp_valid_op, rsp_result_op, rsp_error_op, exp_rv, exp_rr, exp_re);
      end
      if (c == 1) begin
        checks++;
        if (rsp_result_op[0] !== 32'hFFFF_FFFE || rsp_result_op[1] !== 32'd1) begin
          errors++;
          $display("FAIL rr_values: r0=%h r1=%h required r0=fffffffe r1=00000001",
                   rsp_result_op[0], rsp_result_op[1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v_tab [6] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [N-1:0] r_tab [6] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    for (int c = 0; c < 6; c++) begin
      req_valid = v_tab[c]; rsp_ready = r_tab[c]; flush = 0;
      for (int i = 0; i < N; i++) begin
        req_op[i] = ALU_ADD; req_a[i] = 32'(100 * c + i); req_b[i] = 32'd1;
      end
      @(negedge clk); model_eval();
      checks++;
      if (req_ready_op !== exp_ready || alu_operand_a_op !== exp_a) begin
        errors++;
        $display("FAIL bp_grant c=%0d: ready=%b a=%h required ready=%b a=%h",
                 c, req_ready_op, alu_operand_a_op, exp_ready, exp_a);
      end
      if (c >= 2) begin
        checks++;
        if (req_ready_op !== ((c == 5) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL bp_only0 c=%0d: ready=%b required %b", c, req_ready_op, (c == 5) ? 2'b10 : 2'b01);
        end
      end
      tick();
      checks++;
      if (rsp_valid_op !== exp_rv || rsp_result_op !== exp_rr || rsp_error_op !== exp_re) begin
        errors++;
        $display("FAIL bp_rsp c=%0d: v=%b r=%h required v=%b r=%h", c, rsp_valid_op, rsp_result_op, exp_rv, exp_rr);
      end
    end
    checks++;
    if (rsp_valid_op[1] !== 1'b1 || rsp_result_op[1] !== 32'd502) begin
      errors++;
      $display("FAIL bp_refill: v1=%b r1=%0d required v1=1 r1=502", rsp_valid_op[1], rsp_result_op[1]);
    end
  endtask

  task automatic test_error();
    req_valid = 2'b01; rsp_ready = 2'b11; flush = 0;
    req_op[0] = ALU_MUL; req_a[0] = 32'd6; req_b[0] = 32'd7;
    @(negedge clk); model_eval();
    checks++;
    if (req_ready_op !== 2'b01 || alu_operator_op !== ALU_MUL) begin
      errors++;
      $display("FAIL err_grant: ready=%b op=%0d required ready=01 op=%0d", req_ready_op, alu_operator_op, ALU_MUL);
    end
    tick();
    checks++;
    if (rsp_valid_op[0] !== 1'b1 || rsp_result_op[0] !== 32'd0 || rsp_error_op[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_capture: v=%b r=%h e=%b required v=1 r=0 e=1",
               rsp_valid_op[0], rsp_result_op[0], rsp_error_op[0]);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 4; c++) begin
      req_valid = 2'b11; flush = (c == 2);
      rsp_ready = (c < 2) ? 2'b11 : 2'b00;
      for (int i = 0; i < N; i++) begin
        req_op[i] = ALU_XOR; req_a[i] = rand_data(); req_b[i] = rand_data();
      end
      @(negedge clk); model_eval();
      checks++;
      if (req_ready_op !== exp_ready || alu_enable_op !== exp_en) begin
        errors++;
        $display("FAIL flush_grant c=%0d: ready=%b en=%b required ready=%b en=%b",
                 c, req_ready_op, alu_enable_op, exp_ready, exp_en);
      end
      if (c >= 2) begin
        checks++;
        if (req_ready_op !== ((c == 2) ? 2'b00 : 2'b10)) begin
          errors++;
          $display("FAIL flush_ptr c=%0d: ready=%b required %b", c, req_ready_op, (c == 2) ? 2'b00 : 2'b10);
        end
      end
      tick();
      checks++;
      if (rsp_valid_op !== exp_rv || rsp_result_op !== exp_rr || rsp_error_op !== exp_re) begin
        errors++;
        $display("FAIL flush_rsp c=%0d: v=%b r=%h required v=%b r=%h", c, rsp_valid_op, rsp_result_op, exp_rv, exp_rr);
      end
      if (c == 2) begin
        checks++;
        if (rsp_valid_op !== 2'b00) begin
          errors++;
          $display("FAIL flush_clear: v=%b required 00", rsp_valid_op);
        end
      end
    end
  endtask

  task automatic test_random(int cycles);
    for (int c = 0; c < cycles; c++) begin
      rand_inputs(5);
      @(negedge clk); model_eval();
      checks++;
      if (req_ready_op !== exp_ready || alu_enable_op !== exp_en || alu_operator_op !== exp_op ||
          alu_operand_a_op !== exp_a || alu_operand_b_op !== exp_b) begin
        errors++;
        $display("FAIL rand_grant c=%0d: ready=%b op=%0d a=%h b=%h required ready=%b op=%0d a=%h b=%h",
                 c, req_ready_op, alu_operator_op, alu_operand_a_op, alu_operand_b_op,
                 exp_ready, exp_op, exp_a, exp_b);
      end
      tick();
      checks++;
      if (rsp_valid_op !== exp_rv || rsp_result_op !== exp_rr || rsp_error_op !== exp_re) begin
        errors++;
        $display("FAIL rand_rsp c=%0d: v=%b r=%h e=%b required v=%b r=%h e=%b",
                 c, rsp_valid_op, rsp_result_op, rsp_error_op, exp_rv, exp_rr, exp_re);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b11; rsp_ready = 2'b11; flush = 0;
    for (int i = 0; i < N; i++) begin
      req_op[i] = ALU_OR; req_a[i] = 32'hA5A5_0000; req_b[i] = 32'(i + 1);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (req_ready_op !== '0 || alu_enable_op !== 1'b0 || rsp_valid_op !== '0 ||
        rsp_result_op !== '0 || rsp_error_op !== '0) begin
      errors++;
      $display("FAIL midreset: ready=%b en=%b v=%b r=%h e=%b required all zero",
               req_ready_op, alu_enable_op, rsp_valid_op, rsp_result_op, rsp_error_op);
    end
    model_reset();
    reset = 1;
    #1;
    model_eval();
    checks++;
    if (req_ready_op !== exp_ready || req_ready_op !== 2'b01) begin
      errors++;
      $display("FAIL midreset_regrant: ready=%b required 01", req_ready_op);
    end
    tick();
    test_random(20);
  endtask

  initial begin
    flush = 0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) req_op[i] = ALU_ADD;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_error();
    test_flush();
    test_random(400);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU between up to four requesters, for example the execute stage and the branch/address unit. It grants at most one request per cycle and drives the ALU operator and operands from the granted requester. It registers the ALU result into a per-requester response slot, which holds the result until that requester accepts it. The block sits between the decode/execute-side requesters and the ALU.

## Interface
- NUM_REQ, default 2: number of requesters, legal range 2..4.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush_ip  input  1  synchronous flush of all response slots.
- req_valid_ip  input  NUM_REQ  per-requester request valid.
- req_op_ip  input  NUM_REQ x alu_opcode_e  per-requester ALU operation.
- req_a_ip  input  NUM_REQ x 32  per-requester operand A.
- req_b_ip  input  NUM_REQ x 32  per-requester operand B.
- req_ready_op  output  NUM_REQ  one-hot-or-zero grant; a request is accepted when valid and ready are both high.
- alu_enable_op  output  1  high in a grant cycle.
- alu_operator_op  output  alu_opcode_e  operator of the granted request; ALU_ADD when idle.
- alu_operand_a_op  output  32  operand A of the granted request; 0 when idle.
- alu_operand_b_op  output  32  operand B of the granted request; 0 when idle.
- alu_result_ip  input  32  ALU result, combinational from the ALU operator/operand outputs.
- alu_valid_ip  input  1  ALU result validity.
- rsp_valid_op  output  NUM_REQ  response slot full.
- rsp_result_op  output  NUM_REQ x 32  registered result.
- rsp_error_op  output  NUM_REQ  set when the captured alu_valid_ip was 0 (unsupported operator).
- rsp_ready_ip  input  NUM_REQ  requester consumes its response.

## Operation
- **Eligibility.** Requester i is eligible when req_valid_ip[i]=1 and its slot is free in that cycle.
  - The slot is free when rsp_valid_op[i]=0, or when rsp_valid_op[i]=1 and rsp_ready_ip[i]=1 in the same cycle (drain-and-refill).
  - No requester is eligible while flush_ip=1.
- **Round-robin pointer.** State ptr has width clog2(NUM_REQ) and reset value 0.
  - Search order is ptr, ptr+1, … with wrap modulo NUM_REQ. The first eligible requester wins.
  - After a grant to requester g, ptr <= (g+1) mod NUM_REQ.
  - With no grant, ptr holds.
- **Grant cycle.**
  - req_ready_op[g]=1 and alu_enable_op=1.
  - The ALU outputs carry requester g's op and operands.
  - At the clock edge, slot g captures result <= alu_result_ip, error <= ~alu_valid_ip, valid <= 1.
- **Response slot.** A full slot holds its result and error bits stable until rsp_ready_ip[i]=1.
  - On drain with no refill, valid <= 0; result and error hold their last value.
  - rsp_ready_ip[i] while the slot is empty has no effect.
- **Flush.** flush_ip=1 clears all rsp_valid_op at the edge, masks all grants in that cycle, and leaves ptr unchanged.
- **Ready rule.** req_ready_op never depends on req_valid_ip of the same requester other than through eligibility, and it is never asserted for a non-valid request.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) forces:
  - req_ready_op=0, alu_enable_op=0, alu_operator_op=ALU_ADD, alu operands 0.
  - rsp_valid_op=0, rsp_result_op=0, rsp_error_op=0.
  - ptr=0.
- Latency: a request accepted in cycle N has its response visible (rsp_valid_op=1) in cycle N+1.
- Throughput: one grant per cycle across all requesters.
  - A single requester can sustain one request per cycle if it asserts rsp_ready_ip each cycle.
- Fairness: a continuously eligible requester is granted within NUM_REQ cycles.
- Outputs req_ready_op and the alu_* outputs are combinational from state and inputs. No combinational path runs from alu_result_ip to any output.
- Reset asserted mid-operation discards all pending responses. An in-flight grant in that cycle is lost.

## Test plan
- **Reset.** Hold reset=0 with all req_valid_ip=1 -> all outputs at reset values; after release, first grant goes to requester 0.
- **Single request.** Requester 0: ALU_ADD, a=5, b=7, accepted in cycle N -> rsp_valid_op[0]=1, rsp_result_op[0]=12, rsp_error_op[0]=0 in cycle N+1; the slot stays at 12 until rsp_ready_ip[0]=1.
- **Round-robin.** NUM_REQ=2, both requesters valid every cycle, rsp_ready_ip always 1 -> grants alternate 0,1,0,1, and each response matches its operands (e.g. ALU_SUB 3-5 gives 0xFFFFFFFE; ALU_SLTS -1<1 gives 1).
- **Backpressure.** Slot 1 full with rsp_ready_ip[1]=0 while both requesters are valid -> only requester 0 is granted. Raising rsp_ready_ip[1] then produces a drain-and-refill in the same cycle (rsp_valid_op[1] stays 1 with the new result).
- **Error capture.** A request with an operator for which the ALU returns alu_valid_ip=0 -> rsp_result_op=0, rsp_error_op=1.
- **Flush.** flush_ip=1 while two slots are full and requests are pending -> no req_ready_op that cycle; next cycle all rsp_valid_op=0, ptr unchanged, and arbitration resumes.
